// File: rtl/despejo_pkg.sv
// Shared types and defaults for the register-file dump engine.
package despejo_pkg;

    typedef enum logic [1:0] {
        OCIOSO,
        LER,
        ENVIAR,
        FIM
    } estado_t;

    localparam int NUM_REGS_PADRAO      = 32;
    localparam int BYTES_PALAVRA_PADRAO = 4;
    localparam int LARG_END             = 5;
    localparam int LARG_PALAVRA         = 32;

endpackage

// File: rtl/serializador_palavra.sv
// Word-to-byte serializer: loads a 32-bit word and shifts it out LSB first.
module serializador_palavra
    import despejo_pkg::*;
#(
    parameter int BYTES_PALAVRA = BYTES_PALAVRA_PADRAO
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    i_carregar,
    input  logic                    i_deslocar,
    input  logic [LARG_PALAVRA-1:0] i_palavra,
    output logic [7:0]              o_byte,
    output logic                    o_ultimo
);

    localparam int LARG_CNT = (BYTES_PALAVRA > 1) ? $clog2(BYTES_PALAVRA) : 1;

    logic [LARG_PALAVRA-1:0] r_desloc;
    logic [LARG_CNT-1:0]     r_cont;

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_desloc <= '0;
            r_cont   <= '0;
        end else if (i_carregar) begin
            r_desloc <= i_palavra;
            r_cont   <= '0;
        end else if (i_deslocar) begin
            r_desloc <= {8'h00, r_desloc[LARG_PALAVRA-1:8]};
            r_cont   <= r_cont + 1'b1;
        end
    end

    assign o_byte   = r_desloc[7:0];
    assign o_ultimo = (r_cont == LARG_CNT'(BYTES_PALAVRA - 1));

endmodule

// File: rtl/despejo_registradores.sv
// Dumps every register of the register file as a byte stream with valid/ready.
module despejo_registradores
    import despejo_pkg::*;
#(
    parameter int NUM_REGS      = NUM_REGS_PADRAO,
    parameter int BYTES_PALAVRA = BYTES_PALAVRA_PADRAO
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    iniciar,
    input  logic                    cancelar,
    input  logic [LARG_PALAVRA-1:0] dado_reg,
    input  logic                    pronto_saida,
    output logic [LARG_END-1:0]     endereco_reg,
    output logic [7:0]              byte_saida,
    output logic                    valido_saida,
    output logic                    ocupado,
    output logic                    concluido
);

    estado_t             r_estado;
    estado_t             w_prox;
    logic [LARG_END-1:0] r_end;
    logic                r_concluido;
    logic                w_carregar;
    logic                w_transf;
    logic                w_ultimo;
    logic                w_end_ult;
    logic [7:0]          w_byte;

    assign w_transf  = (r_estado == ENVIAR) && pronto_saida && !cancelar;
    assign w_end_ult = (r_end == LARG_END'(NUM_REGS - 1));

    always_comb begin
        w_prox     = r_estado;
        w_carregar = 1'b0;
        unique case (r_estado)
            OCIOSO: begin
                if (iniciar)
                    w_prox = LER;
            end
            LER: begin
                w_carregar = 1'b1;
                w_prox     = ENVIAR;
            end
            ENVIAR: begin
                if (w_transf && w_ultimo)
                    w_prox = w_end_ult ? FIM : LER;
            end
            FIM: begin
                w_prox = OCIOSO;
            end
            default: begin
                w_prox = OCIOSO;
            end
        endcase
        // Abort wins over any transfer or completion in the same cycle.
        if (cancelar && (r_estado != OCIOSO))
            w_prox = OCIOSO;
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_estado    <= OCIOSO;
            r_end       <= '0;
            r_concluido <= 1'b0;
        end else begin
            r_estado    <= w_prox;
            r_concluido <= (r_estado == FIM) && !cancelar;
            if ((r_estado == OCIOSO) && iniciar)
                r_end <= '0;
            else if (w_transf && w_ultimo && !w_end_ult)
                r_end <= r_end + 1'b1;
        end
    end

    serializador_palavra #(
        .BYTES_PALAVRA(BYTES_PALAVRA)
    ) u_serializador (
        .clock     (clock),
        .reset     (reset),
        .i_carregar(w_carregar),
        .i_deslocar(w_transf),
        .i_palavra (dado_reg),
        .o_byte    (w_byte),
        .o_ultimo  (w_ultimo)
    );

    assign endereco_reg = r_end;
    assign byte_saida   = w_byte;
    assign valido_saida = (r_estado == ENVIAR);
    assign ocupado      = (r_estado != OCIOSO);
    assign concluido    = r_concluido;

endmodule

// File: tb/tb_despejo_registradores.sv
// Scoreboard bench: default 32x4 dump plus a 2x1 configuration.
module tb_despejo_registradores;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        iniciar = 1'b0;
    logic        cancelar = 1'b0;
    logic        pronto = 1'b1;
    logic        iniciar_b = 1'b0;
    logic        cancelar_b = 1'b0;
    logic        pronto_b = 1'b1;

    logic [31:0] dado_a, dado_b;
    logic [4:0]  end_a, end_b;
    logic [7:0]  byte_a, byte_b;
    logic        val_a, ocu_a, con_a;
    logic        val_b, ocu_b, con_b;

    int          cyc = 0;
    int          n_cmp = 0;
    int          n_err = 0;
    logic [7:0]  qa[$];
    logic [7:0]  qb[$];
    int          ca[$];
    int          cb[$];

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    assign dado_a = 32'hA000_0000 + {27'd0, end_a};
    assign dado_b = 32'h0000_00B0 + {27'd0, end_b};

    despejo_registradores dut_a (
        .clock       (clock),
        .reset       (reset),
        .iniciar     (iniciar),
        .cancelar    (cancelar),
        .dado_reg    (dado_a),
        .pronto_saida(pronto),
        .endereco_reg(end_a),
        .byte_saida  (byte_a),
        .valido_saida(val_a),
        .ocupado     (ocu_a),
        .concluido   (con_a)
    );

    despejo_registradores #(
        .NUM_REGS     (2),
        .BYTES_PALAVRA(1)
    ) dut_b (
        .clock       (clock),
        .reset       (reset),
        .iniciar     (iniciar_b),
        .cancelar    (cancelar_b),
        .dado_reg    (dado_b),
        .pronto_saida(pronto_b),
        .endereco_reg(end_b),
        .byte_saida  (byte_b),
        .valido_saida(val_b),
        .ocupado     (ocu_b),
        .concluido   (con_b)
    );

    // Monitor A: byte stream, stall stability and completion timing.
    logic       hold_a = 1'b0;
    logic [7:0] hold_byte = 8'h00;
    always @(negedge clock) begin
        logic [7:0] e;
        int         t;
        if (hold_a) begin
            n_cmp++;
            if (!val_a || byte_a !== hold_byte) begin
                n_err++;
                $display("FAIL hold_a: got val=%b byte=%h expected val=1 byte=%h",
                         val_a, byte_a, hold_byte);
            end
        end
        hold_a    = reset && !cancelar && val_a && !pronto;
        hold_byte = byte_a;
        if (reset && val_a && pronto && !cancelar) begin
            n_cmp++;
            if (qa.size() == 0) begin
                n_err++;
                $display("FAIL byte_a: got %h expected no byte", byte_a);
            end else begin
                e = qa.pop_front();
                if (byte_a !== e) begin
                    n_err++;
                    $display("FAIL byte_a: got %h expected %h", byte_a, e);
                end
            end
        end
        if (con_a) begin
            n_cmp++;
            if (ca.size() == 0) begin
                n_err++;
                $display("FAIL concluido_a: got pulse at %0d expected none", cyc);
            end else begin
                t = ca.pop_front();
                if (t >= 0 && cyc != t) begin
                    n_err++;
                    $display("FAIL concluido_a: got cycle %0d expected %0d", cyc, t);
                end
            end
        end
    end

    // Monitor B: small configuration.
    always @(negedge clock) begin
        logic [7:0] e;
        int         t;
        if (reset && val_b && pronto_b) begin
            n_cmp++;
            if (qb.size() == 0) begin
                n_err++;
                $display("FAIL byte_b: got %h expected no byte", byte_b);
            end else begin
                e = qb.pop_front();
                if (byte_b !== e) begin
                    n_err++;
                    $display("FAIL byte_b: got %h expected %h", byte_b, e);
                end
            end
        end
        if (con_b) begin
            n_cmp++;
            if (cb.size() == 0) begin
                n_err++;
                $display("FAIL concluido_b: got pulse at %0d expected none", cyc);
            end else begin
                t = cb.pop_front();
                if (cyc != t) begin
                    n_err++;
                    $display("FAIL concluido_b: got cycle %0d expected %0d", cyc, t);
                end
            end
        end
    end

    task automatic chk(input string nome, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nome, got, exp);
        end
    endtask

    task automatic chk_reset_a(input string nome);
        chk({nome, "_end"}, 32'(end_a), 32'd0);
        chk({nome, "_byte"}, 32'(byte_a), 32'd0);
        chk({nome, "_val"}, 32'(val_a), 32'd0);
        chk({nome, "_ocu"}, 32'(ocu_a), 32'd0);
        chk({nome, "_con"}, 32'(con_a), 32'd0);
    endtask

    task automatic push_reg_a(input int i);
        logic [31:0] w;
        w = 32'hA000_0000 + 32'(i);
        for (int b = 0; b < 4; b++)
            qa.push_back(w[8*b +: 8]);
    endtask

    task automatic start_a(output int t0);
        @(posedge clock);
        #1 iniciar = 1'b1;
        t0 = cyc;
        @(posedge clock);
        #1 iniciar = 1'b0;
    endtask

    task automatic wait_idle_a(input int budget, input bit rnd, input string nome);
        int k;
        k = 0;
        while ((qa.size() != 0 || ca.size() != 0 || ocu_a) && k < budget) begin
            @(posedge clock);
            #1 k++;
            if (rnd)
                pronto = 1'($urandom_range(0, 1));
        end
        pronto = 1'b1;
        n_cmp++;
        if (k >= budget) begin
            n_err++;
            $display("FAIL %s: got no finish expected within %0d cycles", nome, budget);
        end
    endtask

    initial begin
        int t0;
        int k;

        repeat (3) @(posedge clock);
        #1 chk_reset_a("reset");
        chk("reset_val_b", 32'(val_b), 32'd0);
        reset = 1'b1;

        // Full dump, downstream always ready.
        start_a(t0);
        for (int i = 0; i < 32; i++) push_reg_a(i);
        ca.push_back(t0 + 162);
        wait_idle_a(300, 1'b0, "dump_full");

        // Same dump with random backpressure.
        start_a(t0);
        for (int i = 0; i < 32; i++) push_reg_a(i);
        ca.push_back(-1);
        wait_idle_a(1500, 1'b1, "dump_stall");

        // Extra iniciar mid-dump has no effect.
        start_a(t0);
        for (int i = 0; i < 32; i++) push_reg_a(i);
        ca.push_back(t0 + 162);
        repeat (50) @(posedge clock);
        #1 iniciar = 1'b1;
        @(posedge clock);
        #1 iniciar = 1'b0;
        wait_idle_a(300, 1'b0, "dump_reinit");

        // Cancel while byte 2 of register 5 is presented (cycle 29).
        start_a(t0);
        for (int i = 0; i < 5; i++) push_reg_a(i);
        qa.push_back(8'h05);
        qa.push_back(8'h00);
        repeat (28) @(posedge clock);
        #1 cancelar = 1'b1;
        chk("cancel_at_end", 32'(end_a), 32'd5);
        chk("cancel_at_val", 32'(val_a), 32'd1);
        @(posedge clock);
        #1 cancelar = 1'b0;
        chk("cancel_val", 32'(val_a), 32'd0);
        chk("cancel_ocu", 32'(ocu_a), 32'd0);
        repeat (20) @(posedge clock);
        #1 chk("cancel_left", 32'(qa.size()), 32'd0);

        // Reset pulse during register 17 (cycle 88, byte 1 presented).
        start_a(t0);
        for (int i = 0; i < 17; i++) push_reg_a(i);
        qa.push_back(8'h11);
        repeat (87) @(posedge clock);
        #1 chk("rst17_end", 32'(end_a), 32'd17);
        reset = 1'b0;
        @(posedge clock);
        #1 reset = 1'b1;
        chk_reset_a("rst17");
        repeat (20) @(posedge clock);
        #1 chk("rst17_left", 32'(qa.size()), 32'd0);
        chk("rst17_idle", 32'(ocu_a), 32'd0);

        // Restart after reset begins again at register 0.
        start_a(t0);
        chk("restart_end", 32'(end_a), 32'd0);
        for (int i = 0; i < 32; i++) push_reg_a(i);
        ca.push_back(t0 + 162);
        wait_idle_a(300, 1'b0, "dump_restart");

        // NUM_REGS=2, BYTES_PALAVRA=1.
        @(posedge clock);
        #1 iniciar_b = 1'b1;
        t0 = cyc;
        qb.push_back(8'hB0);
        qb.push_back(8'hB1);
        cb.push_back(t0 + 6);
        @(posedge clock);
        #1 iniciar_b = 1'b0;
        k = 0;
        while ((qb.size() != 0 || cb.size() != 0 || ocu_b) && k < 50) begin
            @(posedge clock);
            #1 k++;
        end
        chk("dump_b_timeout", 32'(k < 50), 32'd1);

        repeat (5) @(posedge clock);
        #1 chk("final_qa", 32'(qa.size()), 32'd0);
        chk("final_ca", 32'(ca.size()), 32'd0);
        chk("final_qb", 32'(qb.size()), 32'd0);
        chk("final_cb", 32'(cb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/despejo_registradores.md
DESPEJO_REGISTRADORES -- requirements
Module: despejo_registradores

Interface
REQ-001 Parameter NUM_REGS, default 32: number of registers scanned, indices 0..NUM_REGS-1.
REQ-002 Parameter BYTES_PALAVRA, default 4: bytes emitted per 32-bit register.
REQ-003 clock  input  1  single clock; all state updates on posedge clock.
REQ-004 reset  input  1  synchronous, active-low reset; sampled only on posedge clock.
REQ-005 iniciar  input  1  one-cycle start request for a full dump.
REQ-006 cancelar  input  1  abort the dump in progress.
REQ-007 dado_reg  input  32  register-file read data for endereco_reg; combinational, same cycle.
REQ-008 pronto_saida  input  1  downstream ready for byte_saida.
REQ-009 endereco_reg  output  5  register index driven to the register-file read port.
REQ-010 byte_saida  output  8  current output byte.
REQ-011 valido_saida  output  1  byte_saida is valid.
REQ-012 ocupado  output  1  dump in progress.
REQ-013 concluido  output  1  one-cycle pulse after the last byte of the last register is accepted.

Function
REQ-014 The FSM SHALL use the states OCIOSO, LER, ENVIAR and FIM.
REQ-015 In OCIOSO with iniciar=1, the block SHALL set endereco_reg=0, assert ocupado and enter LER on the next cycle.
REQ-016 In LER, the block SHALL capture dado_reg into a 32-bit shift register, clear the byte counter and enter ENVIAR on the next cycle.
REQ-017 In ENVIAR, valido_saida SHALL be 1 and byte_saida SHALL equal the low byte of the shift register; bytes go out LSB first.
REQ-018 A byte SHALL transfer only on a cycle with valido_saida=1 and pronto_saida=1; on transfer the shift register SHALL shift right by 8 and the byte counter SHALL increment.
REQ-019 While valido_saida=1 and pronto_saida=0, byte_saida and valido_saida SHALL hold stable.
REQ-020 When byte BYTES_PALAVRA-1 transfers and endereco_reg<NUM_REGS-1, endereco_reg SHALL increment and the FSM SHALL return to LER.
REQ-021 When byte BYTES_PALAVRA-1 transfers and endereco_reg=NUM_REGS-1, the FSM SHALL enter FIM.
REQ-022 In FIM, concluido SHALL be 1 for exactly one cycle, ocupado SHALL drop, and the FSM SHALL return to OCIOSO on the next cycle.
REQ-023 Throughput SHALL be one LER cycle plus BYTES_PALAVRA transfer cycles per register; the minimum total is NUM_REGS*(1+BYTES_PALAVRA)+2 cycles from iniciar to concluido.
REQ-024 iniciar SHALL be ignored whenever the FSM is not in OCIOSO.
REQ-025 cancelar=1 in any non-OCIOSO state SHALL force OCIOSO on the next cycle, deassert valido_saida and ocupado, and suppress concluido; cancelar SHALL take priority over a simultaneous transfer.
REQ-026 endereco_reg SHALL never exceed NUM_REGS-1 and SHALL NOT wrap.
REQ-027 The block SHALL only read the register file and SHALL never drive any write control.

Reset
REQ-028 With reset=0 at a clock edge, the block SHALL set the FSM to OCIOSO and set endereco_reg=0, byte_saida=0, valido_saida=0, ocupado=0 and concluido=0.
REQ-029 Reset mid-dump SHALL abandon the dump; no byte or pulse SHALL appear until a new iniciar is received after reset=1.
REQ-030 Reset SHALL take priority over cancelar and iniciar.

Structure
REQ-031 A shared package despejo_pkg SHALL hold the state enum (OCIOSO, LER, ENVIAR, FIM) and the default constants NUM_REGS=32 and BYTES_PALAVRA=4.
REQ-032 The shift register and byte counter SHALL live in the sub-module serializador_palavra (ports: load, shift, word in, byte out, last-byte flag); the FSM and the address counter SHALL stay in the top level.

Verification
REQ-033 Register model preloaded with regs[i]=32'hA0000000+i, iniciar pulse, pronto_saida=1 -> 128 bytes appear in order 00,00,00,A0,01,00,00,A0,...; concluido pulses at cycle 162 after iniciar.
REQ-034 Same dump with pronto_saida toggled pseudo-randomly -> the byte stream is identical, with no byte lost or duplicated while stalled.
REQ-035 cancelar asserted during byte 2 of register 5 -> valido_saida=0 and ocupado=0 on the next cycle, and no concluido pulse appears.
REQ-036 iniciar pulsed again mid-dump -> no effect; the stream and concluido timing match REQ-033.
REQ-037 reset=0 for one cycle during register 17 -> all outputs are at reset values on the next cycle; a new iniciar restarts the dump from register 0.
REQ-038 NUM_REGS=2, BYTES_PALAVRA=1 -> 2 bytes are output and concluido pulses at cycle 6.
